// File: rtl/gpio_arb_pkg.sv
// Shared types, response codes and the round-robin search used by the
// GPIO register-port arbiter and other shared-resource controllers.
package gpio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic RSP_OK      = 1'b0;
    localparam logic RSP_TIMEOUT = 1'b1;
    localparam int   MAX_REQ     = 8;

    // Returns {found, index}: first set bit of valid_vec at or above ptr, wrapping at num.
    function automatic logic [3:0] rr_pick(input logic [7:0] valid_vec,
                                           input int ptr,
                                           input int num);
        logic [3:0] pick;
        int         j;
        pick = 4'd0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = ptr + k;
            if (j >= num) begin
                j = j - num;
            end
            if ((k < num) && !pick[3] && valid_vec[j[2:0]]) begin
                pick = {1'b1, j[2:0]};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/gpio_rr_arbiter.sv
// Combinational round-robin arbiter: valid vector plus priority pointer in,
// one-hot grant and its index out.
module gpio_rr_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [7:0] valid_ext_s;
    logic [3:0] pick_s;

    // Upward search from the pointer; unused upper requester slots read as idle.
    always_comb begin
        valid_ext_s                = 8'd0;
        valid_ext_s[NUM_REQ-1:0]   = valid;
        pick_s                     = rr_pick(valid_ext_s, int'(ptr), NUM_REQ);
        grant_any                  = pick_s[3];
        grant_idx                  = pick_s[IDX_W-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = pick_s[3] && (pick_s[2:0] == 3'(i));
        end
    end

endmodule

// File: rtl/gpio_reg_arbiter.sv
// Shares the GPIO register port among NUM_REQ requesters: round-robin grant,
// strobe sequencing until reg_ack, response routing and stall timeout.
module gpio_reg_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_be,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic                              rsp_err,
    output logic [ADDR_WIDTH-1:0]             reg_addr,
    output logic [DATA_WIDTH-1:0]             reg_wdata,
    output logic [DATA_WIDTH/8-1:0]           reg_be,
    output logic                              reg_we,
    output logic                              reg_re,
    input  logic [DATA_WIDTH-1:0]             reg_rdata,
    input  logic                              reg_ack,
    output logic                              busy,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    arb_state_t        state_r;
    logic [IDX_W-1:0]  rr_ptr_r;
    logic [CNT_W-1:0]  tmo_cnt_r;

    logic [NUM_REQ-1:0]    grant_s;
    logic [IDX_W-1:0]      grant_idx_s;
    logic                  grant_any_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    logic [BE_W-1:0]       sel_be_s;

    gpio_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .valid     (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // Accept pulse exists only while IDLE is evaluating a new winner.
    always_comb begin
        if (state_r == IDLE) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Winner's payload slice, captured on the grant edge.
    always_comb begin
        sel_we_s    = req_we[grant_idx_s];
        sel_addr_s  = req_addr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_s = req_wdata[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
        sel_be_s    = req_be[grant_idx_s*BE_W +: BE_W];
    end

    assign busy = (state_r != IDLE);

    // Access sequencer: grant, hold strobe until ack or timeout, then one response pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            rr_ptr_r  <= '0;
            tmo_cnt_r <= '0;
            grant_id  <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_be    <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        grant_id  <= grant_idx_s;
                        reg_addr  <= sel_addr_s;
                        reg_wdata <= sel_wdata_s;
                        reg_be    <= sel_be_s;
                        reg_we    <= sel_we_s;
                        reg_re    <= !sel_we_s;
                        tmo_cnt_r <= '0;
                        state_r   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (reg_ack) begin
                        rsp_rdata <= reg_we ? '0 : reg_rdata;
                        rsp_err   <= RSP_OK;
                        rsp_valid <= NUM_REQ'(1) << grant_id;
                        reg_we    <= 1'b0;
                        reg_re    <= 1'b0;
                        state_r   <= RESP;
                    end else if (tmo_cnt_r == CNT_W'(TIMEOUT - 1)) begin
                        rsp_rdata <= '0;
                        rsp_err   <= RSP_TIMEOUT;
                        rsp_valid <= NUM_REQ'(1) << grant_id;
                        reg_we    <= 1'b0;
                        reg_re    <= 1'b0;
                        state_r   <= RESP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    // Winner drops to lowest priority for the next round.
                    if (grant_id == IDX_W'(NUM_REQ - 1)) begin
                        rr_ptr_r <= '0;
                    end else begin
                        rr_ptr_r <= grant_id + IDX_W'(1);
                    end
                    state_r <= IDLE;
                end
                default: begin
                    reg_we    <= 1'b0;
                    reg_re    <= 1'b0;
                    rsp_valid <= '0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
